// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle datapath, FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define DATAPATH_MC_INSTRET_EN to build the retired-instruction counter.
module datapath_mc #(
  parameter int XLEN        = 64,
  parameter int I_ADDR_BITS = 6,
  parameter int D_ADDR_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [2:0]             phase,
  input  logic [3:0]             alu_op,
  input  logic                   alu_src,
  input  logic [2:0]             imm_sel,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic                   rf_we,
  input  logic [1:0]             rf_src,
  output logic [3:0]             alu_flags,
  output logic [I_ADDR_BITS-1:0] i_mem_addr,
  output logic                   i_mem_req,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_data,
  output logic [D_ADDR_BITS-1:0] d_mem_addr,
  output logic                   d_mem_req,
  output logic                   d_mem_we,
  input  logic                   d_mem_ack,
  output logic [XLEN-1:0]        d_mem_wdata,
  input  logic [XLEN-1:0]        d_mem_rdata,
  output logic                   retire,
  output logic [31:0]            instret
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [I_ADDR_BITS-1:0] pc_q;
  logic [31:0]            ir_q;
  logic [XLEN-1:0]        a_q, b_q, alu_q, mdr_q;
  logic [3:0]             flags_q;
  logic [XLEN-1:0]        rf_q [1:31];

  logic [4:0]             rs1, rs2, rd;
  logic [31:0]            imm32;
  logic [XLEN-1:0]        imm_x, bop, res, wb_val;
  logic                   ovf, lt, taken;
  logic [3:0]             flags_d;
  logic [I_ADDR_BITS-1:0] pc_plus4, pc_imm;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign phase  = state_q;

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign i_mem_req   = rst_n && (state_q == FETCH);
  assign d_mem_req   = rst_n && (state_q == MEM);
  assign d_mem_we    = d_mem_req && mem_wr;
  assign i_mem_addr  = pc_q;
  assign d_mem_addr  = alu_q[D_ADDR_BITS-1:0];
  assign d_mem_wdata = b_q;
  assign retire      = (state_q == WB);
  assign alu_flags   = flags_q;

  // Next-state logic for the five-phase sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (i_mem_ack) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = (mem_rd || mem_wr) ? MEM : WB;
      MEM:     if (d_mem_ack) state_d = WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Immediate extraction, 32-bit form before sign extension.
  always_comb begin
    imm32 = '0;
    unique case (imm_sel)
      3'd0: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                     ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3: imm32 = {ir_q[31:12], 12'b0};
      3'd4: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                     ir_q[20], ir_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_x = XLEN'($signed(imm32));
  assign bop   = alu_src ? imm_x : b_q;

  // ALU result and signed overflow; codes 10-15 alias to add.
  always_comb begin
    res = a_q + bop;
    ovf = 1'b0;
    unique case (alu_op)
      4'd1: res = a_q - bop;
      4'd2: res = a_q & bop;
      4'd3: res = a_q | bop;
      4'd4: res = a_q ^ bop;
      4'd5: res = XLEN'($signed(a_q) < $signed(bop));
      4'd6: res = XLEN'(a_q < bop);
      4'd7: res = a_q << bop[SHW-1:0];
      4'd8: res = a_q >> bop[SHW-1:0];
      4'd9: res = XLEN'($signed(a_q) >>> bop[SHW-1:0]);
      default: res = a_q + bop;
    endcase
    if (alu_op == 4'd1) begin
      ovf = (a_q[XLEN-1] != bop[XLEN-1]) &&
            (res[XLEN-1] != a_q[XLEN-1]);
    end else if (alu_op == 4'd0 || alu_op >= 4'd10) begin
      ovf = (a_q[XLEN-1] == bop[XLEN-1]) &&
            (res[XLEN-1] != a_q[XLEN-1]);
    end
  end

  assign flags_d = {a_q == bop, ovf, res[XLEN-1], res == '0};

  // Branch decision from latched equal flag and signed A<B.
  assign lt = $signed(a_q) < $signed(b_q);

  always_comb begin
    taken = 1'b0;
    if (branch) begin
      unique case (ir_q[14:12])
        3'b000:  taken = flags_q[3];
        3'b001:  taken = !flags_q[3];
        3'b100:  taken = lt;
        3'b101:  taken = !lt;
        default: taken = 1'b0;
      endcase
    end
  end

  assign pc_plus4 = pc_q + I_ADDR_BITS'(4);
  assign pc_imm   = pc_q + imm_x[I_ADDR_BITS-1:0];

  // Write-back source select; code 11 falls back to the ALU.
  always_comb begin
    wb_val = alu_q;
    unique case (rf_src)
      2'b01:   wb_val = mdr_q;
      2'b10:   wb_val = XLEN'(pc_plus4);
      default: wb_val = alu_q;
    endcase
  end

  // Sequencer state and per-phase datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        FETCH: if (i_mem_ack) ir_q <= i_mem_data;
        DECODE: begin
          a_q <= (rs1 == 5'd0) ? '0 : rf_q[rs1];
          b_q <= (rs2 == 5'd0) ? '0 : rf_q[rs2];
        end
        EXEC: begin
          alu_q   <= res;
          flags_q <= flags_d;
        end
        MEM: if (d_mem_ack) mdr_q <= d_mem_rdata;
        WB: pc_q <= (jump || taken) ? pc_imm : pc_plus4;
        default: ;
      endcase
    end
  end

  // Register file; x0 has no storage and reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (state_q == WB && rf_we && rd != 5'd0) begin
      rf_q[rd] <= wb_val;
    end
  end

`ifdef DATAPATH_MC_INSTRET_EN
  logic [31:0] instret_q;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed and randomized instructions against
// an instruction-level reference model of the datapath.
`timescale 1ns/1ps
module tb_datapath_mc;

  localparam int XLEN = 64;
  localparam int IAB  = 6;
  localparam int DAB  = 6;
  localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMIN = -SMAX - 65'sd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3, phase;
  logic [3:0] alu_op = '0;
  logic alu_src = 1'b0;
  logic [2:0] imm_sel = '0;
  logic branch = 1'b0, jump = 1'b0;
  logic mem_rd = 1'b0, mem_wr = 1'b0, rf_we = 1'b0;
  logic [1:0] rf_src = '0;
  logic [3:0] alu_flags;
  logic [IAB-1:0] i_mem_addr;
  logic i_mem_req;
  logic i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [DAB-1:0] d_mem_addr;
  logic d_mem_req, d_mem_we;
  logic d_mem_ack = 1'b0;
  logic [XLEN-1:0] d_mem_wdata;
  logic [XLEN-1:0] d_mem_rdata = '0;
  logic retire;
  logic [31:0] instret;

  always #5 clk = ~clk;

  datapath_mc #(
    .XLEN(XLEN), .I_ADDR_BITS(IAB), .D_ADDR_BITS(DAB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .phase(phase), .alu_op(alu_op), .alu_src(alu_src),
    .imm_sel(imm_sel), .branch(branch), .jump(jump),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we),
    .rf_src(rf_src), .alu_flags(alu_flags),
    .i_mem_addr(i_mem_addr), .i_mem_req(i_mem_req),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .d_mem_addr(d_mem_addr), .d_mem_req(d_mem_req),
    .d_mem_we(d_mem_we), .d_mem_ack(d_mem_ack),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata),
    .retire(retire), .instret(instret)
  );

  typedef struct packed {
    logic [3:0] op;
    logic       src;
    logic [2:0] isel;
    logic       br, jmp, mrd, mwr, we;
    logic [1:0] ws;
  } ctl_t;

  int passed = 0, total = 0, fails = 0;
  logic [63:0] regs [32];
  logic [63:0] dmem [64];
  logic [5:0]  mpc;
  int unsigned retired;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t mk(input int op, src, isel, br, jmp,
                              mrd, mwr, we, ws);
    ctl_t c;
    c.op = 4'(op); c.src = 1'(src); c.isel = 3'(isel);
    c.br = 1'(br); c.jmp = 1'(jmp); c.mrd = 1'(mrd);
    c.mwr = 1'(mwr); c.we = 1'(we); c.ws = 2'(ws);
    return c;
  endfunction

  function automatic ctl_t c_r(input int op);
    return mk(op, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction
  function automatic ctl_t c_i(input int op);
    return mk(op, 1, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic logic [31:0] e_r(input int op, rs2, rs1, rd);
    return {7'd0, 5'(rs2), 5'(rs1), 3'(op), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] e_i(input int imm, rs1, rd);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] e_s(input int imm, rs2, rs1);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'd3, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_l(input int imm, rs1, rd);
    return {12'(imm), 5'(rs1), 3'd3, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] e_b(input int imm, rs2, rs1, f3);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input int imm, rd);
    logic [20:0] m;
    m = 21'(imm);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] e_u(input int imm, rd);
    return {20'(imm), 5'(rd), 7'h37};
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] ir,
                                        input logic [2:0] sel);
    longint v;
    case (sel)
      3'd0: v = longint'($signed(ir[31:20]));
      3'd1: v = longint'($signed({ir[31:25], ir[11:7]}));
      3'd2: v = longint'($signed({ir[31], ir[7], ir[30:25],
                                  ir[11:8], 1'b0}));
      3'd3: v = longint'($signed(ir[31:12])) * 4096;
      3'd4: v = longint'($signed({ir[31], ir[19:12], ir[20],
                                  ir[30:21], 1'b0}));
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_alu(input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] r,
                       output logic ov);
    longint sa, sb;
    logic signed [64:0] ea, eb, w;
    sa = a; sb = b; ea = sa; eb = sb;
    ov = 1'b0;
    case (op)
      4'd1: begin r = a - b; w = ea - eb; ov = (w > SMAX) || (w < SMIN); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd6: r = (a < b) ? 64'd1 : 64'd0;
      4'd7: r = a << b[5:0];
      4'd8: r = a >> b[5:0];
      4'd9: r = sa >>> b[5:0];
      default: begin r = a + b; w = ea + eb; ov = (w > SMAX) || (w < SMIN); end
    endcase
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef DATAPATH_MC_INSTRET_EN
    return 64'(retired);
`else
    return 64'd0;
`endif
  endfunction

  task automatic run(input string tag, input logic [31:0] ir,
                     input ctl_t c, input int iw, input int dw);
    logic [4:0] rs1, rs2, rdi;
    logic [63:0] a, b, imm, bop, r, wbv;
    logic [5:0] addr, npc, p4;
    logic [3:0] fl;
    logic ov, taken, mem;
    int seq[$];
    rs1 = ir[19:15]; rs2 = ir[24:20]; rdi = ir[11:7];
    a = regs[rs1]; b = regs[rs2];
    imm = m_imm(ir, c.isel);
    bop = c.src ? imm : b;
    m_alu(c.op, a, bop, r, ov);
    fl = {a == bop, ov, r[63], r == 64'd0};
    mem = c.mrd || c.mwr;
    addr = r[5:0];
    case (ir[14:12])
      3'b000: taken = c.br && (a == bop);
      3'b001: taken = c.br && (a != bop);
      3'b100: taken = c.br && ($signed(a) < $signed(b));
      3'b101: taken = c.br && !($signed(a) < $signed(b));
      default: taken = 1'b0;
    endcase
    p4 = mpc + 6'd4;
    npc = (c.jmp || taken) ? mpc + imm[5:0] : p4;
    case (c.ws)
      2'b01: wbv = dmem[addr];
      2'b10: wbv = 64'(p4);
      default: wbv = r;
    endcase
    for (int k = 0; k <= iw; k++) seq.push_back(0);
    seq.push_back(1);
    seq.push_back(2);
    if (mem) for (int k = 0; k <= dw; k++) seq.push_back(3);
    seq.push_back(4);
    alu_op = c.op; alu_src = c.src; imm_sel = c.isel;
    branch = c.br; jump = c.jmp; mem_rd = c.mrd;
    mem_wr = c.mwr; rf_we = c.we; rf_src = c.ws;
    for (int k = 0; k < seq.size(); k++) begin
      i_mem_ack = (seq[k] == 0) && (k == iw);
      i_mem_data = i_mem_ack ? ir : $urandom;
      d_mem_ack = (seq[k] == 3) && (k == iw + 3 + dw);
      d_mem_rdata = d_mem_ack ? dmem[addr] : {$urandom, $urandom};
      chk({tag, ".phase"}, 64'(phase), 64'(seq[k]));
      chk({tag, ".ireq"}, 64'(i_mem_req), 64'(seq[k] == 0));
      chk({tag, ".dreq"}, 64'(d_mem_req), 64'(seq[k] == 3));
      chk({tag, ".retire"}, 64'(retire), 64'(seq[k] == 4));
      if (seq[k] == 0) chk({tag, ".iaddr"}, 64'(i_mem_addr), 64'(mpc));
      if (seq[k] == 1) begin
        chk({tag, ".opcode"}, 64'(opcode), 64'(ir[6:0]));
        chk({tag, ".f3f7"}, 64'({funct7, funct3}),
            64'({ir[31:25], ir[14:12]}));
      end
      if (seq[k] == 3) begin
        chk({tag, ".daddr"}, 64'(d_mem_addr), 64'(addr));
        chk({tag, ".dwe"}, 64'(d_mem_we), 64'(c.mwr));
        if (c.mwr) chk({tag, ".wdata"}, d_mem_wdata, b);
      end
      if (seq[k] == 4) chk({tag, ".flags"}, 64'(alu_flags), 64'(fl));
      @(negedge clk);
    end
    i_mem_ack = 1'b0;
    d_mem_ack = 1'b0;
    if (c.mwr) dmem[addr] = b;
    if (c.we && rdi != 5'd0) regs[rdi] = wbv;
    mpc = npc;
    retired++;
    chk({tag, ".pc"}, 64'(i_mem_addr), 64'(mpc));
    chk({tag, ".back"}, 64'(phase), 64'd0);
    if (rdi != 5'd0) chk({tag, ".rd"}, dut.rf_q[rdi], regs[rdi]);
    chk({tag, ".instret"}, 64'(instret), exp_instret());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_mem_ack = 1'b0;
    d_mem_ack = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mpc = '0;
    retired = 0;
    repeat (2) @(negedge clk);
    chk("rst.phase", 64'(phase), 64'd0);
    chk("rst.ireq", 64'(i_mem_req), 64'd0);
    chk("rst.dreq", 64'(d_mem_req), 64'd0);
    chk("rst.dwe", 64'(d_mem_we), 64'd0);
    chk("rst.retire", 64'(retire), 64'd0);
    chk("rst.flags", 64'(alu_flags), 64'd0);
    chk("rst.instret", 64'(instret), 64'd0);
    chk("rst.ir", 64'({funct7, funct3, opcode}), 64'd0);
    for (int i = 1; i < 32; i++) chk("rst.rf", dut.rf_q[i], 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.ireq", 64'(i_mem_req), 64'd1);
    chk("rel.iaddr", 64'(i_mem_addr), 64'd0);
  endtask

  initial begin
    ctl_t c_st, c_ld, c_br, c_jal, c_lui, c;
    int kind, op, f3;
    logic [31:0] ir;
    c_st  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0);
    c_ld  = mk(0, 1, 0, 0, 0, 1, 0, 1, 1);
    c_br  = mk(1, 0, 2, 1, 0, 0, 0, 0, 0);
    c_jal = mk(0, 1, 4, 0, 1, 0, 0, 1, 2);
    c_lui = mk(0, 1, 3, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 64; i++) dmem[i] = {$urandom, $urandom};

    do_reset();
    run("addi5", e_i(5, 0, 1), c_i(0), 0, 0);
    run("add_x2", e_r(0, 1, 1, 2), c_r(0), 0, 0);
    chk("x2_is_10", dut.rf_q[2], 64'd10);
    run("iwait3", e_i(-7, 0, 3), c_i(0), 3, 0);

    run("li55", e_i(8'h55, 0, 1), c_i(0), 0, 0);
    run("sd", e_s(8, 1, 0), c_st, 0, 2);
    run("ld", e_l(8, 0, 3), c_ld, 0, 2);
    chk("x3_is_55", dut.rf_q[3], 64'h55);

    run("one", e_i(1, 0, 4), c_i(0), 0, 0);
    run("sll63", e_i(63, 4, 4), c_i(7), 0, 0);
    run("max", e_i(-1, 4, 5), c_i(0), 0, 0);
    run("ovf", e_i(1, 5, 6), c_i(0), 0, 0);
    run("sub_ovf", e_r(0, 5, 4, 7), c_r(1), 0, 0);
    run("wr_x0", e_r(0, 5, 4, 0), c_r(0), 0, 0);
    run("op12", e_r(0, 5, 1, 8), c_r(12), 1, 0);
    run("lui", e_u(20'hABCDE, 9), c_lui, 0, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      op = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          ir = e_r(0, $urandom_range(0, 9), $urandom_range(0, 9),
                   $urandom_range(1, 9));
          c = c_r(op);
        end
        2: begin
          ir = e_i($urandom_range(0, 4095), $urandom_range(0, 9),
                   $urandom_range(1, 9));
          c = c_i(op);
        end
        3: begin
          ir = e_s(8 * $urandom_range(0, 7), $urandom_range(0, 9), 0);
          c = c_st;
        end
        4: begin
          ir = e_l(8 * $urandom_range(0, 7), 0, $urandom_range(1, 9));
          c = c_ld;
        end
        default: begin
          f3 = $urandom_range(0, 5);
          ir = e_b(2 * $urandom_range(0, 31) - 32, $urandom_range(0, 9),
                   $urandom_range(0, 9), f3);
          c = c_br;
        end
      endcase
      run("rnd", ir, c, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    ir = e_s(16, 2, 0);
    alu_op = c_st.op; alu_src = c_st.src; imm_sel = c_st.isel;
    branch = 1'b0; jump = 1'b0; mem_rd = 1'b0;
    mem_wr = 1'b1; rf_we = 1'b0; rf_src = '0;
    i_mem_data = ir;
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.dreq", 64'(d_mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.dreq_drop", 64'(d_mem_req), 64'd0);
    chk("mid.dwe_drop", 64'(d_mem_we), 64'd0);
    chk("mid.phase", 64'(phase), 64'd0);
    chk("mid.pc", 64'(i_mem_addr), 64'd0);
    chk("mid.instret", 64'(instret), 64'd0);
    do_reset();

    run("beq_wrap", e_b(-4, 0, 0, 0), c_br, 0, 0);
    chk("pc_60", 64'(i_mem_addr), 64'd60);
    run("at60", e_i(3, 0, 9), c_i(0), 0, 0);
    run("at0", e_i(2, 0, 10), c_i(0), 0, 0);
    run("jal", e_j(8, 1), c_jal, 0, 0);
    chk("jal_x1", dut.rf_q[1], 64'd8);
    chk("jal_pc", 64'(i_mem_addr), 64'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
